mod_arbiter: RTL and testbench

MOD_ARBITER -- requirements
Module: mod_arbiter

---
 rtl/mod_arbiter_if.sv | 33 +++
 rtl/mod_arbiter.sv | 146 ++++++++++++++
 tb/tb_mod_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_arbiter_if.sv
// Requester and engine signal bundle for mod_arbiter.
// The arbiter takes the slave view; the bench (requesters plus engine model) takes the master view.
interface mod_arbiter_if #(
    parameter int W = 16
);
    logic         Req0;
    logic         Req1;
    logic [W-1:0] A0;
    logic [W-1:0] B0;
    logic [W-1:0] A1;
    logic [W-1:0] B1;
    logic         Ack0;
    logic         Ack1;
    logic [W-1:0] Result;
    logic         DivZero;
    logic         Err;
    logic         Busy;
    logic         Eng_Load;
    logic [W-1:0] Eng_A;
    logic [W-1:0] Eng_B;
    logic [W-1:0] Eng_O;
    logic         Eng_Done;

    modport slave (
        input  Req0, Req1, A0, B0, A1, B1, Eng_O, Eng_Done,
        output Ack0, Ack1, Result, DivZero, Err, Busy, Eng_Load, Eng_A, Eng_B
    );

    modport master (
        output Req0, Req1, A0, B0, A1, B1, Eng_O, Eng_Done,
        input  Ack0, Ack1, Result, DivZero, Err, Busy, Eng_Load, Eng_A, Eng_B
    );
endinterface

// File: rtl/mod_arbiter.sv
// Round-robin arbiter sharing one mod-reduction engine between two requesters.
// Define MOD_ARB_TIMEOUT_EN to build in the WAIT-state watchdog (TIMEOUT cycles, then Err).
module mod_arbiter #(
    parameter int W       = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic          Clk,
    input  logic          Reset,
    mod_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WAIT = 3'd2,
        CAPT = 3'd3,
        RESP = 3'd4
    } state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mod_arbiter: TIMEOUT must be at least 1");
    end

    state_t       r_state;
    logic         r_gnt;
    logic         r_last;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_result;
    logic         r_ack0;
    logic         r_ack1;
    logic         r_divzero;
    logic         r_eng_load;

    logic         w_any;
    logic         w_gnt;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;

    // On a tie the requester not served last wins; otherwise whoever is asking.
    assign w_any = bus.Req0 | bus.Req1;
    assign w_gnt = (bus.Req0 & bus.Req1) ? ~r_last : bus.Req1;
    assign w_a   = w_gnt ? bus.A1 : bus.A0;
    assign w_b   = w_gnt ? bus.B1 : bus.B0;

`ifdef MOD_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_tmo_cnt;
    logic          r_err;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_gnt      <= 1'b0;
            r_last     <= 1'b1;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_divzero  <= 1'b0;
            r_eng_load <= 1'b0;
`ifdef MOD_ARB_TIMEOUT_EN
            r_tmo_cnt  <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_eng_load <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_divzero  <= 1'b0;
`ifdef MOD_ARB_TIMEOUT_EN
            r_err      <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt <= w_gnt;
                        r_a   <= w_a;
                        r_b   <= w_b;
                        if (w_b == '0) begin
                            // Division by zero never touches the engine.
                            r_state   <= RESP;
                            r_result  <= '1;
                            r_divzero <= 1'b1;
                            r_ack0    <= ~w_gnt;
                            r_ack1    <= w_gnt;
                        end else begin
                            r_state    <= LOAD;
                            r_eng_load <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    r_state <= WAIT;
`ifdef MOD_ARB_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (bus.Eng_Done) begin
                        r_state <= CAPT;
`ifdef MOD_ARB_TIMEOUT_EN
                    end else if (r_tmo_cnt == CW'(TIMEOUT - 1)) begin
                        r_state  <= RESP;
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_ack0   <= ~r_gnt;
                        r_ack1   <= r_gnt;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    end
                end
                CAPT: begin
                    // The engine's result trails Done by one cycle.
                    r_state  <= RESP;
                    r_result <= bus.Eng_O;
                    r_ack0   <= ~r_gnt;
                    r_ack1   <= r_gnt;
                end
                RESP: begin
                    r_state <= IDLE;
                    r_last  <= r_gnt;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.Ack0     = r_ack0;
    assign bus.Ack1     = r_ack1;
    assign bus.Result   = r_result;
    assign bus.DivZero  = r_divzero;
    assign bus.Busy     = (r_state != IDLE);
    assign bus.Eng_Load = r_eng_load;
    assign bus.Eng_A    = r_a;
    assign bus.Eng_B    = r_b;
`ifdef MOD_ARB_TIMEOUT_EN
    assign bus.Err      = r_err;
`else
    assign bus.Err      = 1'b0;
`endif

endmodule

// File: tb/tb_mod_arbiter.sv
// Directed bench for mod_arbiter: two requesters, an 8-cycle engine model and a result scoreboard.
// Watchdog scenario runs only when MOD_ARB_TIMEOUT_EN is defined.
module tb_mod_arbiter;

`ifdef MOD_ARB_TIMEOUT_EN
    localparam int TMO = 15;
`else
    localparam int TMO = 1023;
`endif

    logic Clk;
    logic Reset;

    mod_arbiter_if #(.W(16)) bus ();

    mod_arbiter #(.W(16), .TIMEOUT(TMO)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int          id;
        logic [15:0] res;
        logic        dz;
        logic        err;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
    } ld_t;

    exp_t sb[$];
    ld_t  ldq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_loads = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine model: Done eight cycles after the load strobe, O = A % B one cycle after Done.
    logic [15:0] eng_a, eng_b;
    int          eng_cnt;
    logic        eng_hang = 1'b0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            eng_cnt      <= 0;
            eng_a        <= 16'd0;
            eng_b        <= 16'd1;
            bus.Eng_Done <= 1'b0;
            bus.Eng_O    <= 16'd0;
        end else begin
            bus.Eng_Done <= 1'b0;
            if (bus.Eng_Done) bus.Eng_O <= eng_a % eng_b;
            if (bus.Eng_Load) begin
                eng_a   <= bus.Eng_A;
                eng_b   <= bus.Eng_B;
                eng_cnt <= 8;
            end else if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1 && !eng_hang) bus.Eng_Done <= 1'b1;
            end
        end
    end

    // Monitor: engine loads and acknowledgements are checked against the queues.
    ld_t  mon_l;
    exp_t mon_e;
    always @(negedge Clk) begin
        if (!Reset) begin
            if (bus.Eng_Load) begin
                n_loads++;
                check("load_expected", 32'(ldq.size() != 0), 32'd1);
                if (ldq.size() != 0) begin
                    mon_l = ldq.pop_front();
                    check("eng_a", 32'(bus.Eng_A), 32'(mon_l.a));
                    check("eng_b", 32'(bus.Eng_B), 32'(mon_l.b));
                end
            end
            if (bus.Ack0 || bus.Ack1) begin
                check("ack_overlap", 32'(bus.Ack0 & bus.Ack1), 32'd0);
                check("ack_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    $display("[TB] ack%0d result=%0h divzero=%0b err=%0b (expected id=%0d result=%0h)",
                             bus.Ack1 ? 1 : 0, bus.Result, bus.DivZero, bus.Err, mon_e.id, mon_e.res);
                    check("ack_id", 32'(bus.Ack1), 32'(mon_e.id));
                    check("result", 32'(bus.Result), 32'(mon_e.res));
                    check("divzero", 32'(bus.DivZero), 32'(mon_e.dz));
                    check("err", 32'(bus.Err), 32'(mon_e.err));
                end
            end
        end
    end

    task automatic push_exp(input int id, input logic [15:0] res, input logic dz, input logic err);
        exp_t e;
        e.id = id; e.res = res; e.dz = dz; e.err = err;
        sb.push_back(e);
    endtask

    task automatic push_ld(input logic [15:0] a, input logic [15:0] b);
        ld_t l;
        l.a = a; l.b = b;
        ldq.push_back(l);
    endtask

    // Waits (bounded) for AckN, then drops ReqN at that edge unless the requester re-requests.
    task automatic wait_ack(input int who, input string tag, input bit keep, output int cycles);
        logic got;
        got = 1'b0;
        cycles = 0;
        for (int n = 1; n <= 200 && !got; n++) begin
            @(negedge Clk);
            if ((who == 0 && bus.Ack0) || (who == 1 && bus.Ack1)) begin
                got = 1'b1;
                cycles = n;
            end
        end
        check(tag, 32'(got), 32'd1);
        @(posedge Clk);
        #1;
        if (!keep) begin
            if (who == 0) bus.Req0 = 1'b0;
            else          bus.Req1 = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_busy"},    32'(bus.Busy), 32'd0);
        check({tag, "_ack0"},    32'(bus.Ack0), 32'd0);
        check({tag, "_ack1"},    32'(bus.Ack1), 32'd0);
        check({tag, "_result"},  32'(bus.Result), 32'd0);
        check({tag, "_divzero"}, 32'(bus.DivZero), 32'd0);
        check({tag, "_err"},     32'(bus.Err), 32'd0);
        check({tag, "_engload"}, 32'(bus.Eng_Load), 32'd0);
        check({tag, "_enga"},    32'(bus.Eng_A), 32'd0);
        check({tag, "_engb"},    32'(bus.Eng_B), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk_zero(tag);
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    logic [15:0] a0_tab [2];
    logic [15:0] b0_tab [2];
    logic [15:0] a1_tab [2];
    logic [15:0] b1_tab [2];

    initial begin
        int cyc;
        int ld0;
        Reset = 1'b1;
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        bus.A0 = '0; bus.B0 = '0; bus.A1 = '0; bus.B1 = '0;
        repeat (3) @(negedge Clk);
        chk_zero("reset");
        Reset = 1'b0;

        // Single request from requester 0.
        @(negedge Clk);
        bus.A0 = 16'd1456; bus.B0 = 16'd9;
        push_ld(16'd1456, 16'd9);
        push_exp(0, 16'd7, 1'b0, 1'b0);
        bus.Req0 = 1'b1;
        wait_ack(0, "t033_ack", 1'b0, cyc);
        check("t033_latency", 32'(cyc), 32'd12);
        @(negedge Clk);
        check("t033_idle_busy", 32'(bus.Busy), 32'd0);

        // Simultaneous requests after reset: requester 0 first.
        do_reset("t034_rst");
        @(negedge Clk);
        bus.A0 = 16'd100; bus.B0 = 16'd7; bus.A1 = 16'd53; bus.B1 = 16'd8;
        push_ld(16'd100, 16'd7); push_ld(16'd53, 16'd8);
        push_exp(0, 16'd2, 1'b0, 1'b0); push_exp(1, 16'd5, 1'b0, 1'b0);
        bus.Req0 = 1'b1; bus.Req1 = 1'b1;
        wait_ack(0, "t034_ack0", 1'b0, cyc);
        wait_ack(1, "t034_ack1", 1'b0, cyc);

        // Four back-to-back rounds with both requesters re-requesting at once.
        a0_tab[0] = 16'd1000; b0_tab[0] = 16'd13; a0_tab[1] = 16'd77;    b0_tab[1] = 16'd10;
        a1_tab[0] = 16'd500;  b1_tab[0] = 16'd7;  a1_tab[1] = 16'd65535; b1_tab[1] = 16'd256;
        push_ld(a0_tab[0], b0_tab[0]); push_ld(a1_tab[0], b1_tab[0]);
        push_ld(a0_tab[1], b0_tab[1]); push_ld(a1_tab[1], b1_tab[1]);
        push_exp(0, 16'd12, 1'b0, 1'b0); push_exp(1, 16'd3, 1'b0, 1'b0);
        push_exp(0, 16'd7, 1'b0, 1'b0);  push_exp(1, 16'd255, 1'b0, 1'b0);
        @(negedge Clk);
        bus.A0 = a0_tab[0]; bus.B0 = b0_tab[0]; bus.A1 = a1_tab[0]; bus.B1 = b1_tab[0];
        bus.Req0 = 1'b1; bus.Req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(k % 2, "t035_ack", (k < 2), cyc);
            if (k == 0) begin bus.A0 = a0_tab[1]; bus.B0 = b0_tab[1]; end
            if (k == 1) begin bus.A1 = a1_tab[1]; bus.B1 = b1_tab[1]; end
            if (k < 3) begin
                @(negedge Clk);
                check("t035_gap_busy_low", 32'(bus.Busy), 32'd0);
                @(negedge Clk);
                check("t035_gap_busy_high", 32'(bus.Busy), 32'd1);
            end
        end

        // Divide by zero: no engine load, Ack one cycle after grant.
        @(negedge Clk);
        ld0 = n_loads;
        bus.A1 = 16'd40; bus.B1 = 16'd0;
        push_exp(1, 16'hFFFF, 1'b1, 1'b0);
        bus.Req1 = 1'b1;
        wait_ack(1, "t036_ack", 1'b0, cyc);
        check("t036_latency", 32'(cyc), 32'd1);
        check("t036_no_load", 32'(n_loads), 32'(ld0));

        // Reset during WAIT drops the operation.
        @(negedge Clk);
        bus.A0 = 16'd999; bus.B0 = 16'd5;
        push_ld(16'd999, 16'd5);
        bus.Req0 = 1'b1;
        repeat (4) @(negedge Clk);
        check("t037_in_wait_busy", 32'(bus.Busy), 32'd1);
        do_reset("t037_rst");
        repeat (14) @(negedge Clk);
        check("t037_idle_after", 32'(bus.Busy), 32'd0);
        bus.A0 = 16'd20; bus.B0 = 16'd6;
        push_ld(16'd20, 16'd6);
        push_exp(0, 16'd2, 1'b0, 1'b0);
        bus.Req0 = 1'b1;
        wait_ack(0, "t037_ack", 1'b0, cyc);

`ifdef MOD_ARB_TIMEOUT_EN
        // Engine never finishes: watchdog aborts after TIMEOUT WAIT cycles.
        @(negedge Clk);
        eng_hang = 1'b1;
        bus.A0 = 16'd123; bus.B0 = 16'd4;
        push_ld(16'd123, 16'd4);
        push_exp(0, 16'd0, 1'b0, 1'b1);
        bus.Req0 = 1'b1;
        wait_ack(0, "t038_ack", 1'b0, cyc);
        check("t038_latency", 32'(cyc), 32'(TMO + 2));
        eng_hang = 1'b0;
        @(negedge Clk);
        bus.A1 = 16'd300; bus.B1 = 16'd17;
        push_ld(16'd300, 16'd17);
        push_exp(1, 16'd11, 1'b0, 1'b0);
        bus.Req1 = 1'b1;
        wait_ack(1, "t038_recover", 1'b0, cyc);
`endif

        repeat (3) @(negedge Clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("ldq_drained", 32'(ldq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
